// File: rtl/bht_param_predictor.sv
// Parametrised branch history / target buffer: fetch-stage lookup, ID-stage prediction register,
// EX-stage training, mispredict flag, sweep-invalidate FSM and saturating statistics.
module bht_param_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    output logic            pred_taken_d,
    output logic [XLEN-1:0] pred_target_d,
    input  logic            upd_valid_e,
    input  logic [XLEN-1:0] upd_pc_e,
    input  logic            upd_taken_e,
    input  logic [XLEN-1:0] upd_target_e,
    input  logic            upd_pred_e,
    input  logic [XLEN-1:0] upd_pred_target_e,
    output logic            mispredict_e,
    input  logic            inv_all,
    output logic            busy,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Table storage; contents are not reset, the post-reset sweep clears valid bits.
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [IDX_W-1:0] w_sweep_idx_nxt;
    logic             w_busy;
    logic             w_sweep_wr;

    logic             r_pred_taken_d;
    logic [XLEN-1:0]  r_pred_target_d;
    logic [31:0]      r_stat_branches;
    logic [31:0]      r_stat_mispred;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_upd_en;
    logic             w_mispredict;

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_valid;
    logic [TAG_W-1:0] w_wr_tag;
    logic [CNT_W-1:0] w_wr_cnt;
    logic [XLEN-1:0]  w_wr_target;

    logic             w_unused;

    assign w_unused = ^{pc_f, upd_pc_e};

    // Fetch lookup on pre-edge contents.
    assign w_f_idx       = pc_f[IDX_W+1:2];
    assign w_f_tag       = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken_f  = w_f_hit && r_cnt[w_f_idx][CNT_W-1] && !w_busy;
    assign pred_target_f = pred_taken_f ? r_target[w_f_idx] : '0;

    assign w_u_idx  = upd_pc_e[IDX_W+1:2];
    assign w_u_tag  = upd_pc_e[IDX_W+TAG_W+1:IDX_W+2];
    assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_upd_en = upd_valid_e && !w_busy && !inv_all;

    // Table-independent, so it stays meaningful during a sweep.
    assign w_mispredict = upd_valid_e && ((upd_taken_e != upd_pred_e) ||
                          (upd_taken_e && (upd_target_e != upd_pred_target_e)));
    assign mispredict_e = rst_n && w_mispredict;

    // Single write port: sweep clears take priority over training.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = w_u_idx;
        w_wr_valid  = 1'b0;
        w_wr_tag    = w_u_tag;
        w_wr_cnt    = '0;
        w_wr_target = upd_target_e;
        if (w_sweep_wr) begin
            w_wr_en     = 1'b1;
            w_wr_idx    = r_sweep_idx;
            w_wr_tag    = '0;
            w_wr_target = '0;
        end else if (w_upd_en) begin
            if (w_u_hit) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b1;
                if (upd_taken_e) begin
                    w_wr_cnt = (r_cnt[w_u_idx] == CNT_MAX) ? CNT_MAX : r_cnt[w_u_idx] + CNT_W'(1);
                end else begin
                    w_wr_cnt    = (r_cnt[w_u_idx] == '0) ? '0 : r_cnt[w_u_idx] - CNT_W'(1);
                    w_wr_target = r_target[w_u_idx];
                end
            end else if (upd_taken_e) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b1;
                w_wr_cnt   = CNT_WEAK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_valid[w_wr_idx]  <= w_wr_valid;
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_cnt[w_wr_idx]    <= w_wr_cnt;
            r_target[w_wr_idx] <= w_wr_target;
        end
    end

    // Sweep FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_idx_nxt;
        end
    end

    // Sweep FSM: next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        case (r_state)
            ST_SWEEP: begin
                if (inv_all) begin
                    w_sweep_idx_nxt = '0;
                end else if (r_sweep_idx == IDX_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_sweep_idx_nxt = '0;
                end else begin
                    w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (inv_all) begin
                    w_state_nxt     = ST_SWEEP;
                    w_sweep_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_SWEEP;
                w_sweep_idx_nxt = '0;
            end
        endcase
    end

    // Sweep FSM: outputs.
    always_comb begin
        w_busy     = 1'b0;
        w_sweep_wr = 1'b0;
        if (r_state == ST_SWEEP) begin
            w_busy     = 1'b1;
            w_sweep_wr = 1'b1;
        end
    end

    assign busy = w_busy;

    // ID-stage copy: clear beats en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (clear) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (en) begin
            r_pred_taken_d  <= pred_taken_f;
            r_pred_target_d <= pred_target_f;
        end
    end

    assign pred_taken_d  = r_pred_taken_d;
    assign pred_target_d = r_pred_target_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (upd_valid_e && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispred != '1)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;

endmodule
